ama_riscv_branch_resolve: RTL and testbench
===========================================

AMA_RISCV_BRANCH_RESOLVE -- requirements
Module: ama_riscv_branch_resolve

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, giving the flush pulse length in cycles; legal range 1..7.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 SHALL have port br_valid, input, 1 bit: a decoded branch is offered.
REQ-005 SHALL have port br_ready, output, 1 bit: the block can accept a branch.
REQ-006 SHALL have port br_funct3, input, 3 bits: the branch funct3 (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
REQ-007 SHALL have ports br_pc and br_imm, input, 32 bits each: the branch PC and the sign-extended B-immediate.
REQ-008 SHALL have ports rs1_data and rs2_data, input, 32 bits each: the compare operands.
REQ-009 SHALL have port pred_taken, input, 1 bit: the fetch-stage prediction for the offered branch.
REQ-010 SHALL have port stall_in, input, 1 bit: a pipeline stall that freezes the block.
REQ-011 SHALL have output ports res_valid (1), res_taken (1), res_illegal (1) and res_target (32): the resolution result.
REQ-012 SHALL have output ports flush (1) and redirect_pc (32): the mispredict recovery request.

Function
REQ-013 SHALL implement an FSM with states IDLE, RESOLVE and FLUSH; br_ready SHALL be high only in IDLE with stall_in low.
REQ-014 SHALL capture funct3, pc, imm, operands and prediction when br_valid && br_ready, then move IDLE->RESOLVE.
REQ-015 In RESOLVE, SHALL compute taken from the registered operands: BEQ=eq, BNE=!eq, BLT/BLTU=lt, BGE/BGEU=!lt; the comparison SHALL be unsigned when funct3[1] is 1.
REQ-016 SHALL treat funct3 010/011 as not-taken, with res_illegal=1 and flush=0.
REQ-017 SHALL pulse res_valid for exactly one cycle in RESOLVE, giving a latency of 1 cycle after acceptance.
REQ-018 SHALL drive res_target = br_pc + br_imm, wrapping modulo 2^32.
REQ-019 SHALL set redirect_pc = taken ? pc+imm : pc+4, wrapping modulo 2^32.
REQ-020 If taken != pred_taken on a legal branch, SHALL go RESOLVE->FLUSH, holding flush high for FLUSH_CYCLES consecutive cycles with redirect_pc held stable.
REQ-021 After the last flush cycle, or from RESOLVE with no mispredict, SHALL return to IDLE.
REQ-022 SHALL NOT accept a branch in the same cycle as RESOLVE; back-to-back throughput is one branch per 2 cycles.
REQ-023 While stall_in is high, the state, registers, flush counter and all outputs SHALL freeze, and a res_valid pulse SHALL be held rather than repeated.
REQ-024 br_valid without br_ready SHALL be ignored; the requester holds the branch.

Reset
REQ-025 rst SHALL take priority over stall_in and any in-flight operation, including mid-FLUSH.
REQ-026 After rst: state IDLE; res_valid, res_taken, res_illegal and flush 0; res_target and redirect_pc 32'h0; flush counter 0; br_ready 1 in the first cycle after rst deasserts.

Configuration
REQ-027 With macro BR_STATS_EN defined, SHALL add outputs cnt_branches (32) and cnt_mispred (32), incrementing on each res_valid and each flush entry respectively, wrapping, cleared by rst.
REQ-028 Without BR_STATS_EN, these ports and their counters SHALL be absent.

Structure
REQ-029 The shared package SHALL hold the funct3 branch encodings and the FSM state enumeration.
REQ-030 SHALL instantiate one ama_riscv_branch_compare sub-module, fed by the registered operands and the unsigned select.

Verification
REQ-031 BEQ with rs1=rs2=5, pred_taken=1, pc=0x100, imm=0x20 -> res_valid after 1 cycle, res_taken=1, res_target=0x120, flush=0.
REQ-032 BLT with rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> taken=1, flush high 2 cycles, redirect_pc=pc+imm; BLTU with the same operands -> taken=0, no flush.
REQ-033 funct3=010 -> res_illegal=1, res_taken=0, flush=0.
REQ-034 Mispredict with stall_in high during flush cycle 1 for 3 cycles -> flush high 5 cycles total, redirect_pc constant.
REQ-035 rst asserted in flush cycle 1 -> next cycle flush=0 and state IDLE, then br_ready=1.
REQ-036 pc=0xFFFFFFFC, not taken, mispredicted -> redirect_pc=0x00000000.

Source files
------------

// File: rtl/ama_riscv_branch_resolve_pkg.sv
// Shared definitions for the branch resolve unit: funct3 branch encodings,
// FSM state enumeration and a small address helper.
package ama_riscv_branch_resolve_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RESOLVE = 2'b01,
        ST_FLUSH   = 2'b10
    } br_state_e;

    // Address arithmetic wraps modulo 2^32 by construction.
    function automatic logic [31:0] addr_add(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/ama_riscv_branch_compare.sv
// Operand comparator for branch resolution: equality and signed/unsigned less-than.
module ama_riscv_branch_compare (
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        is_unsigned,
    output logic        eq,
    output logic        lt
);

    // Pure combinational compare; signedness chosen by funct3[1].
    always_comb begin
        eq = (op_a == op_b);
        if (is_unsigned) begin
            lt = (op_a < op_b);
        end else begin
            lt = ($signed(op_a) < $signed(op_b));
        end
    end

endmodule

// File: rtl/ama_riscv_branch_resolve.sv
// Branch resolve unit: captures a decoded branch, resolves it one cycle later and
// requests a FLUSH_CYCLES-long flush on mispredict. Optional counters: BR_STATS_EN.
module ama_riscv_branch_resolve
    import ama_riscv_branch_resolve_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_funct3,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        pred_taken,
    input  logic        stall_in,
    output logic        res_valid,
    output logic        res_taken,
    output logic        res_illegal,
    output logic [31:0] res_target,
    output logic        flush,
    output logic [31:0] redirect_pc
`ifdef BR_STATS_EN
    ,
    output logic [31:0] cnt_branches,
    output logic [31:0] cnt_mispred
`endif
);

    br_state_e   state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic        pred_q, pred_d;
    logic        res_taken_q, res_taken_d, res_illegal_q, res_illegal_d;
    logic [31:0] redirect_q, redirect_d;

    logic        eq_s, lt_s, taken_s, illegal_s, mispredict_s;
    logic        br_ready_s, accept_s, resolve_fire_s;
    logic [31:0] target_s, pc_plus4_s;

    ama_riscv_branch_compare u_compare (
        .op_a        (rs1_q),
        .op_b        (rs2_q),
        .is_unsigned (funct3_q[1]),
        .eq          (eq_s),
        .lt          (lt_s)
    );

    // Branch condition decode from the registered funct3.
    always_comb begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        case (funct3_q)
            F3_BEQ:           taken_s = eq_s;
            F3_BNE:           taken_s = !eq_s;
            F3_BLT, F3_BLTU:  taken_s = lt_s;
            F3_BGE, F3_BGEU:  taken_s = !lt_s;
            default:          illegal_s = 1'b1;
        endcase
        mispredict_s   = !illegal_s && (taken_s != pred_q);
        target_s       = addr_add(pc_q, imm_q);
        pc_plus4_s     = addr_add(pc_q, 32'd4);
        br_ready_s     = (state_q == ST_IDLE) && !stall_in;
        accept_s       = br_valid && br_ready_s;
        resolve_fire_s = (state_q == ST_RESOLVE) && !stall_in;
    end

    // FSM state and flush counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // FSM next-state logic; a stall freezes state and counter.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_in) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (br_valid) begin
                        state_d = ST_RESOLVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RESOLVE: begin
                    if (mispredict_s) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = 3'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == 3'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // Branch capture on acceptance; result and redirect latched as RESOLVE retires.
    always_comb begin
        funct3_d      = funct3_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        pred_d        = pred_q;
        res_taken_d   = res_taken_q;
        res_illegal_d = res_illegal_q;
        redirect_d    = redirect_q;
        if (accept_s) begin
            funct3_d = br_funct3;
            pc_d     = br_pc;
            imm_d    = br_imm;
            rs1_d    = rs1_data;
            rs2_d    = rs2_data;
            pred_d   = pred_taken;
        end else if (resolve_fire_s) begin
            res_taken_d   = taken_s;
            res_illegal_d = illegal_s;
            redirect_d    = taken_s ? target_s : pc_plus4_s;
        end else begin
            redirect_d = redirect_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q      <= 3'd0;
            pc_q          <= 32'h0;
            imm_q         <= 32'h0;
            rs1_q         <= 32'h0;
            rs2_q         <= 32'h0;
            pred_q        <= 1'b0;
            res_taken_q   <= 1'b0;
            res_illegal_q <= 1'b0;
            redirect_q    <= 32'h0;
        end else begin
            funct3_q      <= funct3_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            pred_q        <= pred_d;
            res_taken_q   <= res_taken_d;
            res_illegal_q <= res_illegal_d;
            redirect_q    <= redirect_d;
        end
    end

    // FSM outputs; during RESOLVE the live result is shown, afterwards the latched one.
    always_comb begin
        br_ready    = br_ready_s;
        res_valid   = (state_q == ST_RESOLVE);
        flush       = (state_q == ST_FLUSH);
        res_target  = target_s;
        redirect_pc = redirect_q;
        if (state_q == ST_RESOLVE) begin
            res_taken   = taken_s;
            res_illegal = illegal_s;
        end else begin
            res_taken   = res_taken_q;
            res_illegal = res_illegal_q;
        end
    end

`ifdef BR_STATS_EN
    logic [31:0] cnt_branches_q, cnt_branches_d, cnt_mispred_q, cnt_mispred_d;

    // Counters advance once per retired resolution, so a stalled pulse counts once.
    always_comb begin
        cnt_branches_d = cnt_branches_q;
        cnt_mispred_d  = cnt_mispred_q;
        if (resolve_fire_s) begin
            cnt_branches_d = cnt_branches_q + 32'd1;
            if (mispredict_s) begin
                cnt_mispred_d = cnt_mispred_q + 32'd1;
            end else begin
                cnt_mispred_d = cnt_mispred_q;
            end
        end else begin
            cnt_branches_d = cnt_branches_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_branches_q <= 32'h0;
            cnt_mispred_q  <= 32'h0;
        end else begin
            cnt_branches_q <= cnt_branches_d;
            cnt_mispred_q  <= cnt_mispred_d;
        end
    end

    assign cnt_branches = cnt_branches_q;
    assign cnt_mispred  = cnt_mispred_q;
`endif

endmodule

// File: tb/tb_ama_riscv_branch_resolve.sv
// Directed self-checking bench for ama_riscv_branch_resolve (default build, FLUSH_CYCLES=2).
module tb_ama_riscv_branch_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [2:0]  br_funct3 = 3'd0;
    logic [31:0] br_pc = 32'h0, br_imm = 32'h0, rs1_data = 32'h0, rs2_data = 32'h0;
    logic        pred_taken = 1'b0;
    logic        stall_in = 1'b0;
    logic        res_valid, res_taken, res_illegal, flush;
    logic [31:0] res_target, redirect_pc;

    int checks = 0;
    int errors = 0;

    ama_riscv_branch_resolve #(.FLUSH_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_funct3   (br_funct3),
        .br_pc       (br_pc),
        .br_imm      (br_imm),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .pred_taken  (pred_taken),
        .stall_in    (stall_in),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_illegal (res_illegal),
        .res_target  (res_target),
        .flush       (flush),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] a, input logic [31:0] b, input logic pred);
        br_funct3 = f3; br_pc = pc; br_imm = imm; rs1_data = a; rs2_data = b; pred_taken = pred;
    endtask

    task automatic offer(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input logic pred);
        set_branch(f3, pc, imm, a, b, pred);
        br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({res_valid, res_taken, res_illegal, flush} !== 4'b0000) begin
            $display("FAIL reset_flags got %b want 0000", {res_valid, res_taken, res_illegal, flush}); errors++;
        end
        checks++;
        if (res_target !== 32'h0 || redirect_pc !== 32'h0) begin
            $display("FAIL reset_addr got %h/%h want 0/0", res_target, redirect_pc); errors++;
        end
        rst = 1'b0;
        checks++;
        if (br_ready !== 1'b1) begin
            $display("FAIL reset_ready got %b want 1", br_ready); errors++;
        end
    endtask

    task automatic test_beq();
        offer(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1);
        checks++;
        if ({res_valid, res_taken, res_illegal, flush, br_ready} !== 5'b11000) begin
            $display("FAIL beq_flags got %b want 11000", {res_valid, res_taken, res_illegal, flush, br_ready}); errors++;
        end
        checks++;
        if (res_target !== 32'h120) begin
            $display("FAIL beq_target got %h want 00000120", res_target); errors++;
        end
        tick();
        checks++;
        if ({res_valid, flush, br_ready} !== 3'b001) begin
            $display("FAIL beq_after got %b want 001", {res_valid, flush, br_ready}); errors++;
        end
    endtask

    task automatic test_blt_bltu();
        offer(3'b100, 32'h200, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        checks++;
        if ({res_valid, res_taken, flush} !== 3'b110 || res_target !== 32'h1F0) begin
            $display("FAIL blt_res got %b/%h want 110/000001f0", {res_valid, res_taken, flush}, res_target); errors++;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({res_valid, flush, br_ready} !== 3'b010 || redirect_pc !== 32'h1F0) begin
                $display("FAIL blt_flush%0d got %b/%h want 010/000001f0", i, {res_valid, flush, br_ready}, redirect_pc); errors++;
            end
        end
        tick();
        checks++;
        if ({flush, br_ready} !== 2'b01) begin
            $display("FAIL blt_end got %b want 01", {flush, br_ready}); errors++;
        end
        offer(3'b110, 32'h200, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        checks++;
        if ({res_valid, res_taken, flush} !== 3'b100) begin
            $display("FAIL bltu_res got %b want 100", {res_valid, res_taken, flush}); errors++;
        end
        tick();
        checks++;
        if ({flush, br_ready} !== 2'b01) begin
            $display("FAIL bltu_noflush got %b want 01", {flush, br_ready}); errors++;
        end
    endtask

    task automatic test_conditions();
        logic [2:0]  f3s [6] = '{3'b001, 3'b001, 3'b101, 3'b111, 3'b101, 3'b000};
        logic [31:0] as  [6] = '{32'd3, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd1};
        logic [31:0] bs  [6] = '{32'd4, 32'd7, 32'd1, 32'd1, 32'd5, 32'd2};
        logic        exps[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            offer(f3s[i], 32'h1000, 32'h8, as[i], bs[i], exps[i]);
            checks++;
            if ({res_valid, res_taken, res_illegal} !== {1'b1, exps[i], 1'b0}) begin
                $display("FAIL cond%0d got %b want %b", i, {res_valid, res_taken, res_illegal}, {1'b1, exps[i], 1'b0}); errors++;
            end
            tick();
            checks++;
            if ({flush, br_ready} !== 2'b01) begin
                $display("FAIL cond%0d_idle got %b want 01", i, {flush, br_ready}); errors++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] f3s [2] = '{3'b010, 3'b011};
        for (int i = 0; i < 2; i++) begin
            offer(f3s[i], 32'h300, 32'h10, 32'd0, 32'd0, 1'b1);
            checks++;
            if ({res_valid, res_taken, res_illegal, flush} !== 4'b1010) begin
                $display("FAIL illegal%0d got %b want 1010", i, {res_valid, res_taken, res_illegal, flush}); errors++;
            end
            tick();
            checks++;
            if ({flush, br_ready} !== 2'b01) begin
                $display("FAIL illegal%0d_noflush got %b want 01", i, {flush, br_ready}); errors++;
            end
        end
    endtask

    task automatic test_stall_flush();
        int flush_cnt = 0;
        int redir_bad = 0;
        offer(3'b001, 32'h400, 32'h40, 32'd1, 32'd2, 1'b0);
        tick();
        if (flush === 1'b1) flush_cnt++;
        if (flush === 1'b1 && redirect_pc !== 32'h440) redir_bad++;
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (flush === 1'b1) flush_cnt++;
            if (flush === 1'b1 && redirect_pc !== 32'h440) redir_bad++;
        end
        stall_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (flush === 1'b1) flush_cnt++;
            if (flush === 1'b1 && redirect_pc !== 32'h440) redir_bad++;
        end
        checks++;
        if (flush_cnt != 5) begin
            $display("FAIL stall_flush_len got %0d want 5", flush_cnt); errors++;
        end
        checks++;
        if (redir_bad != 0) begin
            $display("FAIL stall_flush_redirect got %0d unstable want 0", redir_bad); errors++;
        end
    endtask

    task automatic test_stall_resolve();
        offer(3'b000, 32'h50, 32'h10, 32'd3, 32'd3, 1'b1);
        stall_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({res_valid, res_taken, br_ready} !== 3'b110 || res_target !== 32'h60) begin
                $display("FAIL stall_res%0d got %b/%h want 110/00000060", i, {res_valid, res_taken, br_ready}, res_target); errors++;
            end
        end
        stall_in = 1'b0;
        tick();
        checks++;
        if ({res_valid, flush, br_ready} !== 3'b001) begin
            $display("FAIL stall_res_end got %b want 001", {res_valid, flush, br_ready}); errors++;
        end
    endtask

    task automatic test_back_to_back();
        set_branch(3'b000, 32'h10, 32'h4, 32'd1, 32'd1, 1'b1);
        br_valid = 1'b1;
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_target !== 32'h14) begin
            $display("FAIL b2b_a got %b/%h want 1/00000014", res_valid, res_target); errors++;
        end
        set_branch(3'b001, 32'h20, 32'h10, 32'd1, 32'd1, 1'b0);
        tick();
        checks++;
        if ({res_valid, br_ready} !== 2'b01) begin
            $display("FAIL b2b_gap got %b want 01", {res_valid, br_ready}); errors++;
        end
        tick();
        br_valid = 1'b0;
        checks++;
        if ({res_valid, res_taken} !== 2'b10 || res_target !== 32'h30) begin
            $display("FAIL b2b_b got %b/%h want 10/00000030", {res_valid, res_taken}, res_target); errors++;
        end
        tick();
        stall_in = 1'b1;
        br_valid = 1'b1;
        tick();
        checks++;
        if ({res_valid, br_ready} !== 2'b00) begin
            $display("FAIL stall_ignore got %b want 00", {res_valid, br_ready}); errors++;
        end
        br_valid = 1'b0;
        stall_in = 1'b0;
    endtask

    task automatic test_reset_in_flush();
        offer(3'b000, 32'h80, 32'h8, 32'd1, 32'd2, 1'b1);
        tick();
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h84) begin
            $display("FAIL rstfl_pre got %b/%h want 1/00000084", flush, redirect_pc); errors++;
        end
        rst = 1'b1;
        stall_in = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({flush, res_valid} !== 2'b00 || redirect_pc !== 32'h0) begin
            $display("FAIL rstfl_post got %b/%h want 00/00000000", {flush, res_valid}, redirect_pc); errors++;
        end
        stall_in = 1'b0;
        #1;
        checks++;
        if (br_ready !== 1'b1) begin
            $display("FAIL rstfl_ready got %b want 1", br_ready); errors++;
        end
    endtask

    task automatic test_wrap();
        offer(3'b000, 32'hFFFF_FFFC, 32'h8, 32'd1, 32'd2, 1'b1);
        checks++;
        if ({res_taken, flush} !== 2'b00 || res_target !== 32'h4) begin
            $display("FAIL wrap_res got %b/%h want 00/00000004", {res_taken, flush}, res_target); errors++;
        end
        tick();
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h0) begin
            $display("FAIL wrap_redirect got %b/%h want 1/00000000", flush, redirect_pc); errors++;
        end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_blt_bltu();
        test_conditions();
        test_illegal();
        test_stall_flush();
        test_stall_resolve();
        test_back_to_back();
        test_reset_in_flush();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
